// File: rtl/mux_arb_n_1_if.sv
// mux_arb_n_1_if: bundle of channel inputs, steering controls and the registered
// output handshake shared between the N-to-1 arbiter and whoever drives it.
interface mux_arb_n_1_if #(
  parameter int WIDTH  = 32,
  parameter int NUM_IN = 3,
  parameter int SEL_W  = 2
);
  logic [NUM_IN*WIDTH-1:0] in_data;
  logic [NUM_IN-1:0]       in_valid;
  logic [NUM_IN-1:0]       in_ready;
  logic                    mode;
  logic [SEL_W-1:0]        sel;
  logic [WIDTH-1:0]        out_data;
  logic [SEL_W-1:0]        out_src;
  logic                    out_valid;
  logic                    out_ready;

  // Producer/consumer side: drives channels, steering and output ready.
  modport master (
    output in_data, in_valid, mode, sel, out_ready,
    input  in_ready, out_data, out_src, out_valid
  );

  // Arbiter side.
  modport slave (
    input  in_data, in_valid, mode, sel, out_ready,
    output in_ready, out_data, out_src, out_valid
  );
endinterface

// File: rtl/mux_arb_n_1.sv
// mux_arb_n_1: N-to-1 selector with a single output register. Either steered by
// 'sel' (out-of-range clamps to the last channel) or round-robin over valid
// channels. One-cycle latency, full throughput, drain and load in one cycle.
module mux_arb_n_1 #(
  parameter int WIDTH  = 32,
  parameter int NUM_IN = 3,
  parameter int SEL_W  = 2
) (
  input  logic             clk,
  input  logic             rst,
  mux_arb_n_1_if.slave     bus
);

  localparam logic [SEL_W-1:0] LAST_IDX = SEL_W'(NUM_IN - 1);

  // Output register and round-robin pointer state
  logic [WIDTH-1:0]  out_data_q, out_data_d;
  logic [SEL_W-1:0]  out_src_q,  out_src_d;
  logic              out_valid_q, out_valid_d;
  logic [SEL_W-1:0]  ptr_q,      ptr_d;

  // Grant decision signals
  logic              can_load;
  logic [SEL_W-1:0]  eff_idx;
  logic [SEL_W-1:0]  rr_hi_idx, rr_lo_idx, rr_idx;
  logic              rr_hi_found, rr_lo_found, rr_found;
  logic [SEL_W-1:0]  grant_idx;
  logic              grant_ok;
  logic [NUM_IN-1:0] ready_vec;
  logic              accept;
  logic [WIDTH-1:0]  grant_word;

  // The register may take a new word when empty or when it is being drained now.
  always_comb begin
    can_load = !out_valid_q || bus.out_ready;
  end

  // Steered index: anything past the last channel clamps to the last channel.
  always_comb begin
    eff_idx = (bus.sel > LAST_IDX) ? LAST_IDX : bus.sel;
  end

  // Round-robin scan split into "at or above ptr" and "anywhere"; the descending
  // loop leaves the lowest matching index, so the wrap never visits unused indices.
  always_comb begin
    rr_hi_idx   = '0;
    rr_hi_found = 1'b0;
    rr_lo_idx   = '0;
    rr_lo_found = 1'b0;
    for (int i = NUM_IN - 1; i >= 0; i--) begin
      if (bus.in_valid[i]) begin
        rr_lo_idx   = SEL_W'(i);
        rr_lo_found = 1'b1;
        if (SEL_W'(i) >= ptr_q) begin
          rr_hi_idx   = SEL_W'(i);
          rr_hi_found = 1'b1;
        end
      end
    end
    rr_idx   = rr_hi_found ? rr_hi_idx : rr_lo_idx;
    rr_found = rr_lo_found;
  end

  // Pick the candidate channel according to the current mode.
  always_comb begin
    if (bus.mode) begin
      grant_idx = rr_idx;
      grant_ok  = rr_found;
    end else begin
      grant_idx = eff_idx;
      grant_ok  = 1'b1;
    end
  end

  // One-hot ready to the granted channel; held low while in reset.
  always_comb begin
    ready_vec = '0;
    for (int i = 0; i < NUM_IN; i++) begin
      ready_vec[i] = grant_ok && can_load && !rst && (grant_idx == SEL_W'(i));
    end
  end

  assign bus.in_ready = ready_vec;

  // Word of the granted channel and whether it is actually transferred.
  always_comb begin
    grant_word = '0;
    for (int i = 0; i < NUM_IN; i++) begin
      if (grant_idx == SEL_W'(i)) begin
        grant_word = bus.in_data[i*WIDTH +: WIDTH];
      end
    end
    accept = |(ready_vec & bus.in_valid);
  end

  // Next state: load on accept, empty on a drain with nothing new, else hold.
  always_comb begin
    out_data_d  = out_data_q;
    out_src_d   = out_src_q;
    out_valid_d = out_valid_q;
    ptr_d       = ptr_q;
    if (accept) begin
      out_data_d  = grant_word;
      out_src_d   = grant_idx;
      out_valid_d = 1'b1;
      if (bus.mode) begin
        ptr_d = (grant_idx == LAST_IDX) ? '0 : grant_idx + SEL_W'(1);
      end
    end else if (out_valid_q && bus.out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // State registers with asynchronous clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_data_q  <= '0;
      out_src_q   <= '0;
      out_valid_q <= 1'b0;
      ptr_q       <= '0;
    end else begin
      out_data_q  <= out_data_d;
      out_src_q   <= out_src_d;
      out_valid_q <= out_valid_d;
      ptr_q       <= ptr_d;
    end
  end

  assign bus.out_data  = out_data_q;
  assign bus.out_src   = out_src_q;
  assign bus.out_valid = out_valid_q;

endmodule

// File: tb/tb_mux_arb_n_1.sv
// tb_mux_arb_n_1: directed steps plus a random phase, all checked against a
// cycle-level behavioural model of the arbiter kept in this file.
module tb_mux_arb_n_1;

  localparam int WIDTH  = 32;
  localparam int NUM_IN = 3;
  localparam int SEL_W  = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;

  // 10-time-unit clock
  always #5 clk = ~clk;

  mux_arb_n_1_if #(.WIDTH(WIDTH), .NUM_IN(NUM_IN), .SEL_W(SEL_W)) bus_if ();

  mux_arb_n_1 #(.WIDTH(WIDTH), .NUM_IN(NUM_IN), .SEL_W(SEL_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  logic [WIDTH-1:0] word [NUM_IN];

  // Reference model state
  bit               m_full;
  logic [WIDTH-1:0] m_data;
  int               m_src;
  int               m_ptr;

  task automatic modelReset();
    m_full = 1'b0;
    m_data = '0;
    m_src  = 0;
    m_ptr  = 0;
  endtask

  // Which channel the rules say is offered ready this cycle.
  function automatic logic [NUM_IN-1:0] expReady(input logic [NUM_IN-1:0] v, input logic m,
                                                 input int s, input logic ordy);
    logic [NUM_IN-1:0] r;
    r = '0;
    if (m_full && !ordy) return r;
    if (!m) begin
      r[(s < NUM_IN) ? s : NUM_IN - 1] = 1'b1;
    end else begin
      for (int k = 0; k < NUM_IN; k++) begin
        if (v[(m_ptr + k) % NUM_IN]) begin
          r[(m_ptr + k) % NUM_IN] = 1'b1;
          break;
        end
      end
    end
    return r;
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic [NUM_IN-1:0] v, input logic m,
                               input logic [SEL_W-1:0] s, input logic ordy);
    for (int i = 0; i < NUM_IN; i++) bus_if.in_data[i*WIDTH +: WIDTH] = word[i];
    bus_if.in_valid  = v;
    bus_if.mode      = m;
    bus_if.sel       = s;
    bus_if.out_ready = ordy;
  endtask

  // One clock cycle: drive, check at negedge, then advance the model at posedge.
  task automatic runCycle(input logic [NUM_IN-1:0] v, input logic m,
                          input logic [SEL_W-1:0] s, input logic ordy);
    logic [NUM_IN-1:0] er;
    int g;
    applyStimulus(v, m, s, ordy);
    @(negedge clk);
    er = expReady(v, m, int'(s), ordy);
    checkOutput("out_valid", 64'(bus_if.out_valid), 64'(m_full));
    checkOutput("out_data",  64'(bus_if.out_data),  64'(m_data));
    checkOutput("out_src",   64'(bus_if.out_src),   64'(m_src));
    checkOutput("in_ready",  64'(bus_if.in_ready),  64'(er));
    @(posedge clk);
    g = -1;
    for (int i = 0; i < NUM_IN; i++) if (er[i] && v[i]) g = i;
    if (g >= 0) begin
      m_full = 1'b1;
      m_data = word[g];
      m_src  = g;
      if (m) m_ptr = (g + 1) % NUM_IN;
    end else if (m_full && ordy) begin
      m_full = 1'b0;
    end
    #1;
  endtask

  // Reset with every channel valid; outputs and readies must be cleared.
  task automatic doReset();
    applyStimulus('1, 1'b1, '0, 1'b1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("rst_out_valid", 64'(bus_if.out_valid), 64'(0));
    checkOutput("rst_out_data",  64'(bus_if.out_data),  64'(0));
    checkOutput("rst_out_src",   64'(bus_if.out_src),   64'(0));
    checkOutput("rst_in_ready",  64'(bus_if.in_ready),  64'(0));
    bus_if.in_valid = '0;
    @(negedge clk);
    rst = 1'b0;
    modelReset();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [WIDTH-1:0] steer_exp_data [4];
    int               steer_exp_src  [4];
    int               sparse_exp     [4];
    logic [NUM_IN-1:0] sparse_v      [4];

    steer_exp_data = '{32'hAAAA_AAAA, 32'hBBBB_BBBB, 32'hCCCC_CCCC, 32'hCCCC_CCCC};
    steer_exp_src  = '{0, 1, 2, 2};
    sparse_exp     = '{2, 2, 0, 2};
    sparse_v       = '{3'b100, 3'b100, 3'b101, 3'b101};
    word[0] = 32'hAAAA_AAAA;
    word[1] = 32'hBBBB_BBBB;
    word[2] = 32'hCCCC_CCCC;
    modelReset();

    // Reset, then the first round-robin grant must go to channel 0
    doReset();
    runCycle(3'b111, 1'b1, 2'd0, 1'b1);
    checkOutput("first_rr_src", 64'(bus_if.out_src), 64'(0));

    // Steered legacy selection including the clamped out-of-range select
    doReset();
    for (int s = 0; s < 4; s++) begin
      runCycle(3'b111, 1'b0, SEL_W'(s), 1'b1);
      checkOutput("steer_data", 64'(bus_if.out_data), 64'(steer_exp_data[s]));
      checkOutput("steer_src",  64'(bus_if.out_src),  64'(steer_exp_src[s]));
    end

    // Round-robin fairness with all channels valid
    doReset();
    for (int c = 0; c < 6; c++) begin
      runCycle(3'b111, 1'b1, 2'd0, 1'b1);
      checkOutput("rr_fair_src", 64'(bus_if.out_src), 64'(c % NUM_IN));
    end

    // Sparse round-robin: pointer wraps from 2 straight to 0
    doReset();
    for (int c = 0; c < 4; c++) begin
      runCycle(sparse_v[c], 1'b1, 2'd0, 1'b1);
      checkOutput("rr_sparse_src", 64'(bus_if.out_src), 64'(sparse_exp[c]));
    end

    // Backpressure while full, then drain and load in the same cycle
    doReset();
    runCycle(3'b111, 1'b1, 2'd0, 1'b1);
    for (int c = 0; c < 4; c++) runCycle(3'b111, 1'b1, 2'd0, 1'b0);
    runCycle(3'b111, 1'b1, 2'd0, 1'b1);
    checkOutput("bp_no_bubble", 64'(bus_if.out_valid), 64'(1));
    checkOutput("bp_next_src",  64'(bus_if.out_src),   64'(1));

    // Asynchronous reset between edges while a word is held
    runCycle(3'b111, 1'b1, 2'd0, 1'b0);
    rst = 1'b1;
    #2;
    checkOutput("async_out_valid", 64'(bus_if.out_valid), 64'(0));
    checkOutput("async_in_ready",  64'(bus_if.in_ready),  64'(0));
    checkOutput("async_out_data",  64'(bus_if.out_data),  64'(0));
    bus_if.in_valid = '0;
    @(negedge clk);
    rst = 1'b0;
    modelReset();
    @(posedge clk);
    #1;
    runCycle(3'b110, 1'b1, 2'd0, 1'b1);
    checkOutput("async_next_src", 64'(bus_if.out_src), 64'(1));

    // Random phase: random data, valids, mode, select and consumer stalls
    doReset();
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < NUM_IN; i++) word[i] = $urandom;
      runCycle(NUM_IN'($urandom), 1'($urandom), SEL_W'($urandom_range(0, 3)),
               ($urandom_range(0, 3) != 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
